// File: rtl/fir_ap_ctrl.sv
// fir_ap_ctrl: ap_ctrl / data_len registers and run sequencing for the FIR engine.
// Optional FIR_CTRL_TLAST_CHK_EN adds a sticky tlast-position error (ap_ctrl bit3).
module fir_ap_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_we,
  input  logic [pADDR_WIDTH-1:0] cfg_waddr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic                   cfg_re,
  input  logic [pADDR_WIDTH-1:0] cfg_raddr,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  input  logic                   ss_hs,
  input  logic                   ss_tlast,
  input  logic                   sm_hs,
  output logic                   ss_en,
  output logic                   sm_tlast,
  output logic                   eng_busy,
  output logic                   tap_cfg_en,
  output logic [pDATA_WIDTH-1:0] data_len
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
  localparam logic [pDATA_WIDTH-1:0] ONE       = pDATA_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [pDATA_WIDTH-1:0] len_q;
  logic [pDATA_WIDTH-1:0] in_cnt_q;
  logic [pDATA_WIDTH-1:0] out_cnt_q;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] len_m1;
  logic                   start_q;
  logic                   done_q;
  logic                   err;
  logic                   busy;
  logic                   start_w;
  logic                   len_w;
  logic                   en_w;
  logic                   in_acc;
  logic                   last_beat;
  logic                   fin;
  logic                   ctrl_rd;

  assign busy      = state_q != IDLE;
  assign len_m1    = len_q - ONE;
  assign start_w   = cfg_we && cfg_waddr == ADDR_CTRL
                   && cfg_wdata[0] && !busy;
  assign len_w     = cfg_we && cfg_waddr == ADDR_LEN && !busy;
  assign en_w      = state_q == RUN && in_cnt_q < len_q;
  assign in_acc    = ss_hs && en_w;
  assign last_beat = busy && len_q != '0 && out_cnt_q == len_m1;
  assign fin       = (state_q == RUN && len_q == '0)
                   || (sm_hs && last_beat);
  assign ctrl_rd   = cfg_re && cfg_raddr == ADDR_CTRL;

  assign ss_en      = en_w;
  assign sm_tlast   = last_beat;
  assign eng_busy   = busy;
  assign tap_cfg_en = !busy;
  assign data_len   = len_q;
  assign cfg_rdata  = rdata_q;

  // Run sequencing: start, input phase, drain, back to idle on last output.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_w) state_d = RUN;
      end
      RUN: begin
        if (fin) state_d = IDLE;
        else if (in_cnt_q >= len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (fin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read mux: captures the pre-update register view on cfg_re.
  always_comb begin
    rdata_d = rdata_q;
    if (cfg_re) begin
      rdata_d = '0;
      if (cfg_raddr == ADDR_CTRL) begin
        rdata_d[3:0] = {err, !busy, done_q, start_q};
      end else if (cfg_raddr == ADDR_LEN) begin
        rdata_d = len_q;
      end
    end
  end

  // State register.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  // Registers, stream counters and status bits.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      start_q <= start_w;
      if (len_w) len_q <= cfg_wdata;
      if (start_w) begin
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
      end else begin
        if (in_acc) in_cnt_q <= in_cnt_q + ONE;
        if (busy && sm_hs) out_cnt_q <= out_cnt_q + ONE;
      end
      if (start_w)      done_q <= 1'b0;
      else if (fin)     done_q <= 1'b1;
      else if (ctrl_rd) done_q <= 1'b0;
    end
  end

`ifdef FIR_CTRL_TLAST_CHK_EN
  logic tlast_bad;
  assign tlast_bad = in_acc
                   && (ss_tlast != (in_cnt_q == len_m1));

  // Sticky tlast-position error, cleared only by a new start.
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n)    err <= 1'b0;
    else if (start_w)   err <= 1'b0;
    else if (tlast_bad) err <= 1'b1;
  end
`else
  logic unused_tlast;
  assign unused_tlast = ss_tlast;
  assign err = 1'b0;
`endif

endmodule
